// File: rtl/vdp_pkg.sv
// VDP CPU-port shared types and constants.
// FSM states, port select values and control-byte code bits.
package vdp_pkg;

  localparam int ADDR_W_DEF = 14;

  localparam logic PORT_DATA = 1'b0;
  localparam logic PORT_CTRL = 1'b1;

  // second control byte: bit 7 selects a register
  // write, bit 6 selects write setup over read setup
  localparam int CODE_REG_BIT = 7;
  localparam int CODE_WR_BIT  = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_PEND,
    ST_RD_PEND,
    ST_RD_WAIT
  } vdp_state_e;

endpackage

// File: rtl/vdp_vram_arb.sv
// Fixed-priority VRAM mux: video first, CPU otherwise.
// Read data is tagged per requester through the BRAM latency.
module vdp_vram_arb #(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_grant,
  output logic              cpu_rvalid,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [7:0]        vram_wdata,
  input  logic [7:0]        vram_rdata
);

  logic [RD_LAT-1:0] vid_tag;
  logic [RD_LAT-1:0] cpu_tag;
  logic              cpu_rd;

  assign cpu_grant  = cpu_req & ~vid_req;
  assign cpu_rd     = cpu_grant & ~cpu_we;
  assign vram_we    = cpu_grant & cpu_we;
  assign vram_addr  = vid_req   ? vid_addr :
                      cpu_grant ? cpu_addr : '0;
  assign vram_wdata = vram_we ? cpu_wdata : 8'h00;

  // track which requester owns each read in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_tag <= '0;
      cpu_tag <= '0;
    end else begin
      vid_tag <= RD_LAT'({vid_tag, vid_req});
      cpu_tag <= RD_LAT'({cpu_tag, cpu_rd});
    end
  end

  assign cpu_rvalid = cpu_tag[RD_LAT-1];
  assign cpu_rdata  = vram_rdata;
  assign vid_rdata  = vid_tag[RD_LAT-1] ? vram_rdata : 8'h00;

endmodule

// File: rtl/vdp_port_ctrl.sv
// VDP CPU data/control ports, register file and
// VRAM access sequencer in front of the arbiter.
module vdp_port_ctrl
  import vdp_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = 8,
  parameter int RD_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  io_wr_stb,
  input  logic                  io_rd_stb,
  input  logic                  io_port,
  input  logic [7:0]            cpu_din,
  output logic [7:0]            cpu_dout,
  input  logic [7:0]            status_in,
  output logic                  status_rd,
  output logic                  cpu_wait,
  output logic                  overrun,
  output logic [NUM_REGS*8-1:0] regs,
  input  logic                  vid_req,
  input  logic [ADDR_W-1:0]     vid_addr,
  output logic [7:0]            vid_rdata,
  output logic [ADDR_W-1:0]     vram_addr,
  output logic                  vram_we,
  output logic [7:0]            vram_wdata,
  input  logic [7:0]            vram_rdata
);

  vdp_state_e        state;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        first_byte;
  logic [7:0]        read_ahead;
  logic [7:0]        wdata;
  logic              flag;

  logic       busy;
  logic       ctrl;
  logic       wr_ok;
  logic       rd_ok;
  logic       cpu_req;
  logic       cpu_we;
  logic       cpu_grant;
  logic       cpu_rvalid;
  logic [7:0] cpu_rdata;

  assign busy     = (state != ST_IDLE);
  assign cpu_wait = busy;
  assign ctrl     = (io_port == PORT_CTRL);
  assign wr_ok    = io_wr_stb & ~busy;
  assign rd_ok    = io_rd_stb & ~io_wr_stb & ~busy;
  assign cpu_req  = (state == ST_WR_PEND) |
                    (state == ST_RD_PEND);
  assign cpu_we   = (state == ST_WR_PEND);

  assign status_rd = rd_ok & ctrl;
  assign cpu_dout  = !rd_ok ? 8'h00      :
                     ctrl   ? status_in  :
                              read_ahead;

  vdp_vram_arb #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_arb (
    .clk        (clk),
    .reset_n    (reset_n),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_rdata  (vid_rdata),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (ptr),
    .cpu_wdata  (wdata),
    .cpu_grant  (cpu_grant),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .vram_addr  (vram_addr),
    .vram_we    (vram_we),
    .vram_wdata (vram_wdata),
    .vram_rdata (vram_rdata)
  );

  // port decode, register file and access sequencer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      first_byte <= 8'h00;
      read_ahead <= 8'h00;
      wdata      <= 8'h00;
      flag       <= 1'b0;
      overrun    <= 1'b0;
      regs       <= '0;
    end else begin
      if (((io_wr_stb | io_rd_stb) & busy) |
          (io_wr_stb & io_rd_stb))
        overrun <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          unique case (1'b1)
            wr_ok & ctrl & ~flag: begin
              first_byte <= cpu_din;
              flag       <= 1'b1;
            end
            wr_ok & ctrl & flag: begin
              flag <= 1'b0;
              unique case (1'b1)
                cpu_din[CODE_REG_BIT]: begin
                  if (int'(cpu_din[2:0]) < NUM_REGS)
                    regs[cpu_din[2:0]*8 +: 8] <= first_byte;
                end
                ~cpu_din[CODE_REG_BIT] &
                ~cpu_din[CODE_WR_BIT]: begin
                  ptr   <= ADDR_W'({cpu_din[5:0], first_byte});
                  state <= ST_RD_PEND;
                end
                ~cpu_din[CODE_REG_BIT] &
                cpu_din[CODE_WR_BIT]: begin
                  ptr <= ADDR_W'({cpu_din[5:0], first_byte});
                end
              endcase
            end
            wr_ok & ~ctrl: begin
              flag       <= 1'b0;
              read_ahead <= cpu_din;
              wdata      <= cpu_din;
              state      <= ST_WR_PEND;
            end
            rd_ok & ctrl: begin
              flag <= 1'b0;
            end
            rd_ok & ~ctrl: begin
              flag  <= 1'b0;
              state <= ST_RD_PEND;
            end
            default: ;
          endcase
        end
        ST_WR_PEND: begin
          if (cpu_grant) begin
            ptr   <= ptr + 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_RD_PEND: begin
          if (cpu_grant)
            state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (cpu_rvalid) begin
            read_ahead <= cpu_rdata;
            ptr        <= ptr + 1'b1;
            state      <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Bench for vdp_port_ctrl: directed CPU/video traffic,
// expected VRAM writes, reads and video data via queues.
module tb_vdp_port_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_wr_stb = 1'b0;
  logic        io_rd_stb = 1'b0;
  logic        io_port = 1'b0;
  logic [7:0]  cpu_din = 8'h00;
  logic [7:0]  cpu_dout;
  logic [7:0]  status_in = 8'h9F;
  logic        status_rd;
  logic        cpu_wait;
  logic        overrun;
  logic [63:0] regs;
  logic        vid_req = 1'b0;
  logic [13:0] vid_addr = 14'h0;
  logic [7:0]  vid_rdata;
  logic [13:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata = 8'h00;

  logic [7:0]  mem [0:16383];

  int nvec = 0;
  int nmis = 0;

  logic [21:0] exp_wr[$];
  logic [8:0]  exp_rd[$];
  logic [7:0]  exp_vid[$];
  logic        rd_chk = 1'b0;
  logic        vid_chk_en = 1'b1;
  logic        vid_pend = 1'b0;

  logic [13:0] vtab_a [6] = '{14'h3FFF, 14'h0000,
    14'h0001, 14'h0100, 14'h0101, 14'h0102};
  logic [7:0]  vtab_d [6] = '{8'hAA, 8'h55,
    8'h77, 8'h12, 8'h34, 8'h56};

  vdp_port_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .io_wr_stb  (io_wr_stb),
    .io_rd_stb  (io_rd_stb),
    .io_port    (io_port),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .status_in  (status_in),
    .status_rd  (status_rd),
    .cpu_wait   (cpu_wait),
    .overrun    (overrun),
    .regs       (regs),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_rdata  (vid_rdata),
    .vram_addr  (vram_addr),
    .vram_we    (vram_we),
    .vram_wdata (vram_wdata),
    .vram_rdata (vram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (vram_we) mem[vram_addr] <= vram_wdata;
    vram_rdata <= mem[vram_addr];
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // monitor: VRAM writes, CPU reads, video data
  always @(negedge clk) begin
    if (!reset_n) begin
      vid_pend = 1'b0;
    end else begin
      if (vram_we) begin
        if (exp_wr.size() == 0)
          chk("unexp_wr", {vram_addr, vram_wdata}, 64'h0);
        else
          chk("vram_wr", {vram_addr, vram_wdata},
              exp_wr.pop_front());
      end
      if (rd_chk) begin
        if (exp_rd.size() == 0)
          chk("unexp_rd", {status_rd, cpu_dout}, 64'h0);
        else
          chk("cpu_rd", {status_rd, cpu_dout},
              exp_rd.pop_front());
      end
      if (vid_pend) begin
        if (exp_vid.size() == 0)
          chk("unexp_vid", vid_rdata, 64'h0);
        else
          chk("vid_rdata", vid_rdata, exp_vid.pop_front());
      end
      vid_pend = vid_req & vid_chk_en;
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic stb_wr(input logic port,
                        input logic [7:0] d);
    io_port   = port;
    cpu_din   = d;
    io_wr_stb = 1'b1;
    cyc();
    io_wr_stb = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 50 && cpu_wait; i++) cyc();
    chk(nm, cpu_wait, 64'h0);
  endtask

  task automatic ctl_wr(input logic [7:0] d);
    stb_wr(1'b1, d);
  endtask

  task automatic dat_wr(input logic [13:0] a,
                        input logic [7:0] d);
    exp_wr.push_back({a, d});
    stb_wr(1'b0, d);
    wait_idle("wr_done");
  endtask

  task automatic rd(input logic port,
                    input logic [8:0] e);
    exp_rd.push_back(e);
    io_port   = port;
    io_rd_stb = 1'b1;
    rd_chk    = 1'b1;
    cyc();
    io_rd_stb = 1'b0;
    rd_chk    = 1'b0;
    wait_idle("rd_done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) cyc();
    chk("rst_wait", cpu_wait, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_regs", regs, 0);
    chk("rst_we", vram_we, 0);
    chk("rst_addr", vram_addr, 0);
    chk("rst_dout", cpu_dout, 0);
    chk("rst_vid", vid_rdata, 0);
    reset_n = 1'b1;
    cyc();

    // register write R1 = E0
    ctl_wr(8'hE0);
    ctl_wr(8'h81);
    chk("reg_r1", regs, 64'h0000_0000_0000_E000);
    chk("reg_nowait", cpu_wait, 0);

    // write burst across the address wrap
    ctl_wr(8'hFF);
    ctl_wr(8'h7F);
    chk("setup_nowait", cpu_wait, 0);
    dat_wr(14'h3FFF, 8'hAA);
    dat_wr(14'h0000, 8'h55);
    dat_wr(14'h0001, 8'h77);

    // read-ahead
    ctl_wr(8'h00);
    ctl_wr(8'h41);
    dat_wr(14'h0100, 8'h12);
    dat_wr(14'h0101, 8'h34);
    dat_wr(14'h0102, 8'h56);
    ctl_wr(8'h00);
    ctl_wr(8'h01);
    wait_idle("prefetch");
    rd(1'b0, {1'b0, 8'h12});
    rd(1'b0, {1'b0, 8'h34});
    rd(1'b0, {1'b0, 8'h56});

    // video holds off a pending write for 10 cycles
    exp_wr.push_back({14'h0104, 8'h9C});
    stb_wr(1'b0, 8'h9C);
    for (int i = 0; i < 10; i++) begin
      vid_req  = 1'b1;
      vid_addr = vtab_a[i % 6];
      exp_vid.push_back(vtab_d[i % 6]);
      @(negedge clk);
      chk("arb_wait", cpu_wait, 1);
      chk("arb_no_we", vram_we, 0);
      cyc();
    end
    vid_req = 1'b0;
    @(negedge clk);
    chk("commit_first", vram_we, 1);
    cyc();
    wait_idle("arb_done");

    // video read during CPU RD_WAIT
    ctl_wr(8'h00);
    ctl_wr(8'h01);
    cyc();
    vid_req  = 1'b1;
    vid_addr = 14'h3FFF;
    exp_vid.push_back(8'hAA);
    cyc();
    vid_req = 1'b0;
    wait_idle("tag_done");
    rd(1'b0, {1'b0, 8'h12});

    // status read clears the latch
    ctl_wr(8'h34);
    rd(1'b1, {1'b1, 8'h9F});
    ctl_wr(8'h80);
    chk("latch_clr", regs, 64'h0000_0000_0000_E000);
    ctl_wr(8'h82);
    chk("reg_r2", regs, 64'h0000_0000_0080_E000);

    // strobe during wait is dropped
    chk("ovr_pre", overrun, 0);
    exp_wr.push_back({14'h0102, 8'hC3});
    stb_wr(1'b0, 8'hC3);
    vid_req   = 1'b1;
    vid_addr  = 14'h0000;
    exp_vid.push_back(8'h55);
    cpu_din   = 8'h5A;
    io_wr_stb = 1'b1;
    cyc();
    io_wr_stb = 1'b0;
    exp_vid.push_back(8'h55);
    @(negedge clk);
    chk("ovr_set", overrun, 1);
    chk("ovr_wait", cpu_wait, 1);
    cyc();
    vid_req = 1'b0;
    wait_idle("ovr_done");
    rd(1'b0, {1'b0, 8'hC3});

    // reset in the middle of WR_PEND
    vid_chk_en = 1'b0;
    stb_wr(1'b0, 8'hEE);
    vid_req  = 1'b1;
    vid_addr = 14'h0001;
    cyc();
    cyc();
    #2;
    reset_n  = 1'b0;
    vid_req  = 1'b0;
    vid_addr = 14'h0;
    #1;
    chk("ar_wait", cpu_wait, 0);
    chk("ar_ovr", overrun, 0);
    chk("ar_regs", regs, 0);
    chk("ar_we", vram_we, 0);
    chk("ar_addr", vram_addr, 0);
    chk("ar_wdata", vram_wdata, 0);
    chk("ar_dout", cpu_dout, 0);
    chk("ar_vid", vid_rdata, 0);
    chk("ar_srd", status_rd, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ar_hold_we", vram_we, 0);
    end
    cyc();
    reset_n = 1'b1;
    vid_chk_en = 1'b1;
    repeat (3) cyc();

    // simultaneous strobes: write wins
    io_port   = 1'b1;
    cpu_din   = 8'h11;
    io_wr_stb = 1'b1;
    io_rd_stb = 1'b1;
    @(negedge clk);
    chk("both_srd", status_rd, 0);
    cyc();
    io_wr_stb = 1'b0;
    io_rd_stb = 1'b0;
    chk("both_ovr", overrun, 1);
    ctl_wr(8'h85);
    chk("reg_r5", regs, 64'h0000_1100_0000_0000);

    // pointer restarts at zero after reset
    dat_wr(14'h0000, 8'h66);
    repeat (3) cyc();

    chk("left_wr", exp_wr.size(), 0);
    chk("left_rd", exp_rd.size(), 0);
    chk("left_vid", exp_vid.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
